// File: rtl/vec_pkg.sv
// Shared encodings, sizes and lane arithmetic for the vector execution stage.
// Pure declarations; no latency or flow control of its own.
package vec_pkg;

  localparam int LANES     = 4;
  localparam int LANE_W    = 8;
  localparam int MUL_ITERS = 8;

  localparam logic [1:0] OP_VADD    = 2'b00;
  localparam logic [1:0] OP_VSUB    = 2'b01;
  localparam logic [1:0] OP_VMUL    = 2'b10;
  localparam logic [1:0] OP_VSATADD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    WB   = 2'd3
  } state_t;

  // Single-cycle lane ops; VMUL is handled by the serial lane multipliers.
  function automatic logic [LANE_W-1:0] lane_op(input logic [1:0] op,
                                                input logic [LANE_W-1:0] a,
                                                input logic [LANE_W-1:0] b);
    logic [LANE_W:0]   sum;
    logic [LANE_W-1:0] r;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      OP_VSUB:    r = a - b;
      OP_VSATADD: r = sum[LANE_W] ? '1 : sum[LANE_W-1:0];
      default:    r = sum[LANE_W-1:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lane_mul8.sv
// Serial shift-add multiplier for one 8-bit lane, product truncated to 8 bits.
// One partial product per step; caller sequences idx 0..7, no stall input.
module lane_mul8
  import vec_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              step,
  input  logic [2:0]        idx,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] prod
);

  logic [LANE_W-1:0] acc;

  // prod is the accumulator after the current step, so the final step's
  // result can be registered by the caller on the same edge.
  assign prod = b[idx] ? acc + (a << idx) : acc;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (step) begin
      acc <= prod;
    end
  end

endmodule

// File: rtl/vec_alu_seq.sv
// Lane-wise vector ALU feeding the register file write port.
// Add/sub/satadd: write 2 cycles after accept; mul: 9 cycles. start ignored while busy.
module vec_alu_seq
  import vec_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [LANES*LANE_W-1:0]  vdata1,
  input  logic [LANES*LANE_W-1:0]  vdata2,
  input  logic [1:0]               vdst,
  output logic                     busy,
  output logic                     done,
  output logic [LANES*LANE_W-1:0]  vdataw,
  output logic [1:0]               vregw,
  output logic                     VRFWrite
);

  state_t                    state, state_nxt;
  logic [LANES*LANE_W-1:0]   opa, opb, exec_res, mul_res;
  logic [1:0]                opc;
  logic [2:0]                cnt;
  logic                      accept, mul_step, mul_last;

  assign accept   = (state == IDLE) && start;
  assign mul_step = (state == MUL);
  assign mul_last = mul_step && (cnt == 3'(MUL_ITERS - 1));

  assign busy     = (state != IDLE);
  assign done     = (state == WB);
  assign VRFWrite = (state == WB);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (op == OP_VMUL) ? MUL : EXEC;
      EXEC: state_nxt = WB;
      MUL:  if (mul_last) state_nxt = WB;
      WB:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    exec_res = '0;
    for (int l = 0; l < LANES; l++) begin
      exec_res[l*LANE_W +: LANE_W] = lane_op(opc, opa[l*LANE_W +: LANE_W],
                                             opb[l*LANE_W +: LANE_W]);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_mul8 u_mul (
      .clock (clock),
      .reset (reset),
      .clr   (accept),
      .step  (mul_step),
      .idx   (cnt),
      .a     (opa[g*LANE_W +: LANE_W]),
      .b     (opb[g*LANE_W +: LANE_W]),
      .prod  (mul_res[g*LANE_W +: LANE_W])
    );
  end

  // Operands are frozen at accept so later register-file writes cannot leak in.
  always_ff @(posedge clock) begin
    if (reset) begin
      opa    <= '0;
      opb    <= '0;
      opc    <= '0;
      cnt    <= '0;
      vregw  <= '0;
      vdataw <= '0;
    end else begin
      if (accept) begin
        opa   <= vdata1;
        opb   <= vdata2;
        opc   <= op;
        vregw <= vdst;
        cnt   <= '0;
      end
      if (state == EXEC) vdataw <= exec_res;
      if (mul_step) begin
        cnt <= cnt + 3'd1;
        if (mul_last) vdataw <= mul_res;
      end
    end
  end

endmodule

// File: tb/tb_vec_alu_seq.sv
// Directed plus random checks of vec_alu_seq against a lane-arithmetic model.
module tb_vec_alu_seq;
  import vec_pkg::*;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [1:0]  op, vdst, vregw;
  logic [31:0] vdata1, vdata2, vdataw;
  logic        busy, done, VRFWrite;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;

  vec_alu_seq dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .vdata1   (vdata1),
    .vdata2   (vdata2),
    .vdst     (vdst),
    .busy     (busy),
    .done     (done),
    .vdataw   (vdataw),
    .vregw    (vregw),
    .VRFWrite (VRFWrite)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (VRFWrite === 1'b1) wr_count <= wr_count + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] res;
    int x, y, r;
    res = '0;
    for (int l = 0; l < 4; l++) begin
      x = int'(a[8*l +: 8]);
      y = int'(b[8*l +: 8]);
      case (o)
        OP_VADD: r = (x + y) % 256;
        OP_VSUB: r = (x - y + 256) % 256;
        OP_VMUL: r = (x * y) % 256;
        default: r = (x + y > 255) ? 255 : x + y;
      endcase
      res[8*l +: 8] = 8'(r);
    end
    return res;
  endfunction

  // Issue one op, scramble the operand buses after accept, check timing and result.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] d, input logic [31:0] exp, input string tag);
    int lat, w0;
    lat = (o == OP_VMUL) ? 9 : 2;
    @(negedge clock);
    start = 1'b1; op = o; vdata1 = a; vdata2 = b; vdst = d;
    w0 = wr_count;
    for (int c = 1; c < lat; c++) begin
      @(negedge clock);
      start = 1'b0; vdata1 = $urandom; vdata2 = $urandom; vdst = 2'($urandom);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nowr"}, 32'(VRFWrite), 32'd0);
    end
    @(negedge clock);
    chk({tag, "_wb_wr"}, 32'(VRFWrite), 32'd1);
    chk({tag, "_wb_done"}, 32'(done), 32'd1);
    chk({tag, "_wb_busy"}, 32'(busy), 32'd1);
    chk({tag, "_vregw"}, 32'(vregw), 32'(d));
    chk({tag, "_vdataw"}, vdataw, exp);
    @(negedge clock);
    chk({tag, "_post_wr"}, 32'(VRFWrite), 32'd0);
    chk({tag, "_post_busy"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, vdataw, exp);
    chk({tag, "_nwrites"}, 32'(wr_count - w0), 32'd1);
  endtask

  initial begin
    logic [1:0]  ro, rd;
    logic [31:0] ra, rb;
    int w0;

    reset = 1'b1; start = 1'b0; op = '0; vdata1 = '0; vdata2 = '0; vdst = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr", 32'(VRFWrite), 32'd0);
    chk("rst_vdataw", vdataw, 32'd0);
    chk("rst_vregw", 32'(vregw), 32'd0);
    reset = 1'b0;

    run_op(OP_VADD,    32'h01FF7F10, 32'h01010101, 2'd2, 32'h02008011, "vadd");
    run_op(OP_VSUB,    32'h00100203, 32'h01010101, 2'd1, 32'hFF0F0102, "vsub");
    run_op(OP_VSATADD, 32'hF0807F01, 32'h20807F01, 2'd0, 32'hFFFFFE02, "vsat");
    run_op(OP_VMUL,    32'h03FF1002, 32'h05FF1081, 2'd3, 32'h0F010002, "vmul");

    // start held with a different op while busy; then a new VSUB in cycle 3
    @(negedge clock);
    start = 1'b1; op = OP_VADD; vdata1 = 32'h01FF7F10; vdata2 = 32'h01010101; vdst = 2'd1;
    w0 = wr_count;
    @(negedge clock);
    op = OP_VMUL; vdata1 = $urandom; vdata2 = $urandom; vdst = 2'd0;
    chk("hold_c1_busy", 32'(busy), 32'd1);
    @(negedge clock);
    chk("hold_c2_wr", 32'(VRFWrite), 32'd1);
    chk("hold_c2_data", vdataw, 32'h02008011);
    chk("hold_c2_vregw", 32'(vregw), 32'd1);
    @(posedge clock);
    #1;
    op = OP_VSUB; vdata1 = 32'h00100203; vdata2 = 32'h01010101; vdst = 2'd2;
    @(negedge clock);
    chk("hold_c3_busy", 32'(busy), 32'd0);
    chk("hold_c3_nwr", 32'(wr_count - w0), 32'd1);
    @(negedge clock);
    start = 1'b0;
    chk("hold_c4_busy", 32'(busy), 32'd1);
    chk("hold_c4_nowr", 32'(VRFWrite), 32'd0);
    @(negedge clock);
    chk("hold_c5_wr", 32'(VRFWrite), 32'd1);
    chk("hold_c5_data", vdataw, 32'hFF0F0102);
    chk("hold_c5_vregw", 32'(vregw), 32'd2);
    @(negedge clock);
    chk("hold_c6_nwr", 32'(wr_count - w0), 32'd2);

    // reset in the middle of a multiply
    @(negedge clock);
    start = 1'b1; op = OP_VMUL; vdata1 = 32'h03FF1002; vdata2 = 32'h05FF1081; vdst = 2'd3;
    w0 = wr_count;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_wr", 32'(VRFWrite), 32'd0);
    chk("mrst_vdataw", vdataw, 32'd0);
    chk("mrst_vregw", 32'(vregw), 32'd0);
    reset = 1'b0;
    repeat (7) @(negedge clock);
    chk("mrst_nowrite", 32'(wr_count - w0), 32'd0);
    chk("mrst_idle", 32'(busy), 32'd0);

    // reset and start together: reset wins
    @(negedge clock);
    reset = 1'b1; start = 1'b1; op = OP_VADD; vdata1 = 32'h11111111; vdata2 = 32'h22222222;
    w0 = wr_count;
    @(negedge clock);
    chk("rs_busy", 32'(busy), 32'd0);
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clock);
    chk("rs_idle", 32'(busy), 32'd0);
    chk("rs_nowrite", 32'(wr_count - w0), 32'd0);

    // random ops against the lane model
    for (int k = 0; k < 24; k++) begin
      ro = 2'($urandom);
      rd = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      if (k % 4 == 0) ra = 32'hFFFFFFFF;
      run_op(ro, ra, rb, rd, model(ro, ra, rb), $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_alu_seq.md
Name: vec_alu_seq

Overview:
- Vector execution stage directly downstream of the 4-entry x 32-bit vector register file.
- Consumes the two combinational read operands, computes a lane-wise result over 4 x 8-bit lanes, and drives the register file write port with a one-cycle write strobe.
- Single-cycle ops finish in a fixed short latency; lane-wise multiply is iterative (shift-add, 8 cycles).
- Start/busy/done handshake with the control FSM.

Parameters:
- LANES, 4, number of lanes per vector word.
- LANE_W, 8, bits per lane; LANES*LANE_W = 32.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 VADD, 01 VSUB, 10 VMUL, 11 VSATADD.
- vdata1  input  32  operand A from the register file read port 1.
- vdata2  input  32  operand B from the register file read port 2.
- vdst  input  2  destination vector register index, captured with start.
- busy  output  1  high from the cycle after accept through the WB cycle.
- done  output  1  one-cycle pulse in the WB cycle.
- vdataw  output  32  result word to the register file write data.
- vregw  output  2  destination index to the register file write address.
- VRFWrite  output  1  write strobe; high only in the WB cycle.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high (`reset`), sampled on the rising edge.
- Reset values: state=IDLE; busy, done and VRFWrite = 0; vdataw = 0; vregw = 0; internal operand, accumulator and counter registers = 0.
- All outputs are registered or decoded from state; no combinational path from any input to any output.

States:
- IDLE: if start=1 at an edge, capture vdata1, vdata2, op and vdst. Go to MUL when op=10, otherwise EXEC. If start=0, stay.
- EXEC: one cycle. Compute the lane-wise result and register it. Go to WB.
- MUL: iteration counter i = 0..7. For each lane, if B[i]=1 then acc += (A << i), truncated to LANE_W bits. Go to WB after i=7.
- WB: VRFWrite=1, done=1, vdataw=result, vregw=captured vdst. Go to IDLE.

Timing (start accepted at the end of cycle 0):
- Single-cycle ops: busy in cycles 1-2; VRFWrite/done in cycle 2; next start accepted in cycle 3.
- VMUL: busy in cycles 1-9; VRFWrite/done in cycle 9.

Arithmetic per lane (unsigned 8-bit, no carry or borrow between lanes):
- VADD: (a+b) mod 256.
- VSUB: (a-b) mod 256.
- VSATADD: min(a+b, 255).
- VMUL: (a*b) mod 256.

Boundary conditions:
- start while busy: ignored; operands are not re-captured.
- Operands are captured at accept. vdata1/vdata2 changing afterwards, including from this unit's own write-back, does not affect the result.
- vdst equal to a source register: legal; the write lands in WB.
- vdataw holds its last value after WB; VRFWrite returns to 0.
- Reset mid-operation: on the next edge go to IDLE, with all outputs at reset values. No VRFWrite is issued for the aborted op.
- Reset with start=1 in the same cycle: reset wins; start is not accepted.

Decomposition:
- Shared package vec_pkg holds:
  - op encodings: OP_VADD=2'b00, OP_VSUB=2'b01, OP_VMUL=2'b10, OP_VSATADD=2'b11.
  - state encodings: IDLE, EXEC, MUL, WB.
  - LANES, LANE_W, MUL_ITERS=8.
- One natural sub-module, lane_mul8: a serial shift-add unit for one 8-bit lane, instantiated LANES times and driven by the shared counter.

Test Plan:
- VADD, A=0x01FF7F10, B=0x01010101, vdst=2 -> cycle 2: VRFWrite=1, done=1, vregw=2, vdataw=0x02008011. Cycle 3: VRFWrite=0, busy=0.
- VSUB, A=0x00100203, B=0x01010101 -> vdataw=0xFF0F0102 in cycle 2; no borrow crosses lanes.
- VSATADD, A=0xF0807F01, B=0x20807F01 -> vdataw=0xFFFFFE02 in cycle 2.
- VMUL, A=0x03FF1002, B=0x05FF1081, vdst=3:
  - busy=1 in cycles 1-9, VRFWrite=0 in cycles 1-8.
  - cycle 9: VRFWrite=1, vregw=3, vdataw=0x0F010002.
- VADD accepted; start=1 held with a different op in cycles 1-2 -> that start is ignored and exactly one write occurs in cycle 2. A new VSUB with start in cycle 3 is accepted; its write occurs in cycle 5.
- VMUL started, reset=1 in cycle 4 -> cycle 5: busy=0, done=0, VRFWrite=0, vdataw=0, state IDLE. No write through cycle 12.
